// File: rtl/mm_sequencer.sv
// Initiator for a 2x2 matrix multiplier. It loads eight operand bytes into the multiplier
// through sel_in/input_val/execute, then reads C00..C11 back onto a valid/ready result stream.
module mm_sequencer #(
    parameter int DW        = 8,
    parameter int RW        = 2*DW+1,
    parameter int CALC_WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [1:0]    out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [2:0]    mm_sel_in,
    output logic [DW-1:0] mm_input_val,
    output logic          mm_execute,
    output logic [1:0]    mm_sel_out,
    input  logic [RW-1:0] mm_out
);

    localparam int WW = (CALC_WAIT < 2) ? 1 : $clog2(CALC_WAIT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, SEL, EMIT} state_e;

    state_e        state_q, state_d;
    logic [2:0]    load_cnt_q, load_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    rd_idx_q, rd_idx_d;

    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    mm_sel_in_q, mm_sel_in_d;
    logic [DW-1:0] mm_input_val_q, mm_input_val_d;
    logic          mm_execute_q, mm_execute_d;
    logic [1:0]    mm_sel_out_q, mm_sel_out_d;

    logic          accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no branch can leave it unassigned and infer a latch.
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        rd_idx_d       = rd_idx_q;
        in_ready_d     = in_ready_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_idx_d      = out_idx_q;
        out_last_d     = out_last_q;
        done_d         = 1'b0;
        mm_sel_in_d    = mm_sel_in_q;
        mm_input_val_d = mm_input_val_q;
        mm_execute_d   = 1'b1;
        mm_sel_out_d   = mm_sel_out_q;

        case (state_q)
            IDLE, LOAD: begin
                // The byte index doubles as the multiplier register address.
                if (accept) begin
                    mm_sel_in_d    = load_cnt_q;
                    mm_input_val_d = in_data;
                    mm_execute_d   = 1'b0;
                    load_cnt_d     = load_cnt_q + 3'd1;
                    if (load_cnt_q == 3'd7) begin
                        in_ready_d = 1'b0;
                        wait_cnt_d = WW'(CALC_WAIT);
                        state_d    = CALC;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = LOAD;
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            CALC: begin
                wait_cnt_d = wait_cnt_q - WW'(1);
                if (wait_cnt_q == WW'(1)) begin
                    mm_sel_out_d = rd_idx_q;
                    state_d      = SEL;
                end
            end
            SEL: begin
                out_data_d  = mm_out;
                out_idx_d   = rd_idx_q;
                out_last_d  = (rd_idx_q == 2'd3);
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd_idx_q != 2'd3) begin
                        rd_idx_d     = rd_idx_q + 2'd1;
                        mm_sel_out_d = rd_idx_q + 2'd1;
                        state_d      = SEL;
                    end else begin
                        done_d     = 1'b1;
                        rd_idx_d   = 2'd0;
                        in_ready_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            load_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            rd_idx_q       <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mm_sel_in_q    <= '0;
            mm_input_val_q <= '0;
            mm_execute_q   <= 1'b1;
            mm_sel_out_q   <= '0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            rd_idx_q       <= rd_idx_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            mm_sel_in_q    <= mm_sel_in_d;
            mm_input_val_q <= mm_input_val_d;
            mm_execute_q   <= mm_execute_d;
            mm_sel_out_q   <= mm_sel_out_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = out_idx_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mm_sel_in    = mm_sel_in_q;
    assign mm_input_val = mm_input_val_q;
    assign mm_execute   = mm_execute_q;
    assign mm_sel_out   = mm_sel_out_q;

endmodule

// File: tb/tb_mm_sequencer.sv
// Bench for mm_sequencer: a behavioural 2x2 multiplier sits on the mm_* port, and table-driven
// operand sets plus hand-written backpressure and reset sequences are checked against fixed answers.
module tb_mm_sequencer;

    localparam int DW        = 8;
    localparam int RW        = 2*DW+1;
    localparam int CALC_WAIT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [2:0]    mm_sel_in;
    logic [DW-1:0] mm_input_val;
    logic          mm_execute;
    logic [1:0]    mm_sel_out;
    logic [RW-1:0] mm_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exec_lows = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mm_sequencer #(.DW(DW), .RW(RW), .CALC_WAIT(CALC_WAIT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
        .mm_sel_in(mm_sel_in), .mm_input_val(mm_input_val), .mm_execute(mm_execute),
        .mm_sel_out(mm_sel_out), .mm_out(mm_out)
    );

    // Multiplier model: registers 0..3 hold A00,A01,A10,A11 and 4..7 hold B00,B01,B10,B11.
    logic [DW-1:0] mreg [8] = '{default: '0};
    logic [2:0]    a0_idx, a1_idx, b0_idx, b1_idx;

    always @(posedge clk) if (!mm_execute) mreg[mm_sel_in] <= mm_input_val;

    always_comb begin
        a0_idx = {1'b0, mm_sel_out[1], 1'b0};
        a1_idx = {1'b0, mm_sel_out[1], 1'b1};
        b0_idx = {2'b10, mm_sel_out[0]};
        b1_idx = {2'b11, mm_sel_out[0]};
        mm_out = '0;
        if (mm_execute)
            mm_out = RW'(mreg[a0_idx]) * RW'(mreg[b0_idx]) + RW'(mreg[a1_idx]) * RW'(mreg[b1_idx]);
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!mm_execute) exec_lows <= exec_lows + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        string         name;
        logic [DW-1:0] ops [8];
        logic [RW-1:0] exp [4];
        bit            gaps;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send_byte(input string tag, input logic [DW-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s accept_ready", tag), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_ops(input vec_t v, output int t_last);
        for (int k = 0; k < 8; k++) begin
            send_byte(v.name, v.ops[k]);
            if (v.gaps && k < 7) @(negedge clk);
        end
        t_last = cyc;
    endtask

    // Drains four results while holding a junk byte on in_valid that must stay unaccepted.
    task automatic collect(input vec_t v, input bit bp, input int t_last);
        int got = 0, n = 0, first = -1, rdy_bad = 0;
        bit held = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        while (got < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid && first < 0) first = cyc;
            if (out_valid && in_ready) rdy_bad++;
            if (bp && out_valid && out_idx == 2'd1 && !held) begin
                held = 1;
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    @(negedge clk);
                    check($sformatf("%s hold%0d valid", v.name, h), 32'(out_valid), 32'd1);
                    check($sformatf("%s hold%0d data", v.name, h), 32'(out_data), 32'(v.exp[1]));
                    check($sformatf("%s hold%0d idx", v.name, h), 32'(out_idx), 32'd1);
                    if (in_ready) rdy_bad++;
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s data%0d", v.name, got), 32'(out_data), 32'(v.exp[got]));
                check($sformatf("%s idx%0d", v.name, got), 32'(out_idx), 32'(got));
                check($sformatf("%s last%0d", v.name, got), 32'(out_last), 32'(got == 3));
                got++;
                if (got == 4) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check($sformatf("%s results", v.name), 32'(got), 32'd4);
        check($sformatf("%s latency", v.name), 32'(first - t_last), 32'(CALC_WAIT + 1));
        check($sformatf("%s in_ready_in_readout", v.name), 32'(rdy_bad), 32'd0);
        @(negedge clk);
        check($sformatf("%s done_pulse", v.name), 32'(done), 32'd1);
        check($sformatf("%s busy_after", v.name), 32'(busy), 32'd0);
        check($sformatf("%s in_ready_after", v.name), 32'(in_ready), 32'd1);
        @(negedge clk);
        check($sformatf("%s done_clear", v.name), 32'(done), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit bp);
        int t_last, e0, d0;
        e0 = exec_lows;
        d0 = done_cnt;
        send_ops(v, t_last);
        collect(v, bp, t_last);
        @(negedge clk);
        check($sformatf("%s exec_pulses", v.name), 32'(exec_lows - e0), 32'd8);
        check($sformatf("%s done_count", v.name), 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].name = "basic";    vecs[0].ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[0].exp = '{17'd19, 17'd22, 17'd43, 17'd50};                 vecs[0].gaps = 0;
        vecs[1].name = "all255";   vecs[1].ops = '{default: 8'd255};
        vecs[1].exp = '{default: 17'd130050};                            vecs[1].gaps = 0;
        vecs[2].name = "gaps";     vecs[2].ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[2].exp = '{17'd19, 17'd22, 17'd43, 17'd50};                 vecs[2].gaps = 1;
        vecs[3].name = "identity"; vecs[3].ops = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
        vecs[3].exp = '{17'd9, 17'd8, 17'd7, 17'd6};                     vecs[3].gaps = 0;
        vecs[4].name = "basic2";   vecs[4].ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[4].exp = '{17'd19, 17'd22, 17'd43, 17'd50};                 vecs[4].gaps = 0;
        vecs[5].name = "swap";     vecs[5].ops = '{8'd0, 8'd1, 8'd1, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5};
        vecs[5].exp = '{17'd4, 17'd5, 17'd2, 17'd3};                     vecs[5].gaps = 0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_idx_last", 32'({out_idx, out_last}), 32'd0);
        check("rst busy_done", 32'({busy, done}), 32'd0);
        check("rst mm_sel_in", 32'(mm_sel_in), 32'd0);
        check("rst mm_input_val", 32'(mm_input_val), 32'd0);
        check("rst mm_execute", 32'(mm_execute), 32'd1);
        check("rst mm_sel_out", 32'(mm_sel_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

        // Consumer stalls on C01 for five cycles; values must hold and order must survive.
        run_vec(vecs[0], 1'b1);

        // Reset in the middle of a load, then a full reload.
        for (int k = 0; k < 5; k++) send_byte("abort", vecs[5].ops[k]);
        check("abort busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort mm_execute", 32'(mm_execute), 32'd1);
        check("abort in_ready", 32'(in_ready), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort in_ready_back", 32'(in_ready), 32'd1);
        run_vec(vecs[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
